// File: rtl/rps_pkg.sv
// Shared definitions for the rock-paper-scissors round controller.
//   - Status codes carried in value_player*[4:3].
//   - Hidden-code marker carried in value_player*[2:0] while a player is locked.
//   - Score ceiling and the round FSM state encoding.
package rps_pkg;

  localparam logic [1:0] ST_SEL  = 2'b00;
  localparam logic [1:0] ST_LOCK = 2'b01;
  localparam logic [1:0] ST_WIN  = 2'b10;
  localparam logic [1:0] ST_LOSE = 2'b11;

  localparam logic [2:0] CODE_HIDDEN = 3'd7;
  localparam logic [3:0] SCORE_MAX   = 4'd9;

  typedef enum logic {
    S_SELECT = 1'b0,
    S_REVEAL = 1'b1
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer followed by a stable-high counter.
// Emits a single-cycle press pulse when the synchronized input has been high for
// DEBOUNCE_CYCLES consecutive samples; re-arms only after the input goes low.
// Ports:
//   clk      - system clock
//   rst      - synchronous reset, active-low
//   btn_i    - raw asynchronous button, active-high
//   press_o  - registered one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ARM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      // Pulse only on the D-1 -> D step; the counter then parks at D until
      // the input drops, so a held button cannot fire again.
      press_q <= sync2_q && (cnt_q == CNT_ARM);
      if (!sync2_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/rps_round_ctrl.sv
// Two-player round controller: debounces four buttons, lets each player cycle
// and lock a hidden choice, resolves the round with a generalized
// rock-paper-scissors rule, shows the result for REVEAL_CYCLES cycles and keeps
// saturating per-player scores. NUM_CHOICES must be odd, 3..7.
// Ports:
//   clk, rst                - clock, synchronous active-low reset
//   btn_sel1, btn_lock1     - player 1 raw buttons (async, active-high)
//   btn_sel2, btn_lock2     - player 2 raw buttons
//   value_player1/2 [4:0]   - {status[1:0], code[2:0]}, registered
//   score1/2 [3:0]          - round wins, saturating at 9
//   round_done              - one-cycle pulse on entry to REVEAL
module rps_round_ctrl
  import rps_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_CHOICES     = 3,
  parameter int REVEAL_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_sel1,
  input  logic       btn_lock1,
  input  logic       btn_sel2,
  input  logic       btn_lock2,
  output logic [4:0] value_player1,
  output logic [4:0] value_player2,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       round_done
);

  localparam int RCW = $clog2(REVEAL_CYCLES + 1);
  localparam logic [RCW-1:0] RCNT_LAST   = RCW'(REVEAL_CYCLES - 1);
  localparam logic [2:0]     CHOICE_LAST = 3'(NUM_CHOICES - 1);
  localparam logic [3:0]     NCH4        = 4'(NUM_CHOICES);
  localparam logic [3:0]     HALF4       = 4'((NUM_CHOICES - 1) / 2);

  function automatic logic [2:0] next_choice(input logic [2:0] c);
    return (c == CHOICE_LAST) ? 3'd0 : c + 3'd1;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= SCORE_MAX) ? SCORE_MAX : s + 4'd1;
  endfunction

  logic sel1_p, lock1_p, sel2_p, lock2_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel1 (
    .clk(clk), .rst(rst), .btn_i(btn_sel1), .press_o(sel1_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lock1 (
    .clk(clk), .rst(rst), .btn_i(btn_lock1), .press_o(lock1_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel2 (
    .clk(clk), .rst(rst), .btn_i(btn_sel2), .press_o(sel2_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lock2 (
    .clk(clk), .rst(rst), .btn_i(btn_lock2), .press_o(lock2_p));

  state_e         state_q;
  logic [RCW-1:0] rcnt_q;
  logic [2:0]     choice1_q, choice2_q;
  logic           lock1_q, lock2_q;
  logic [4:0]     value1_q, value2_q;
  logic [3:0]     score1_q, score2_q;
  logic           round_done_q;

  // Selection-phase next values. A lock pulse also suppresses a sel pulse in
  // the same cycle, so the locked choice is the one shown before the press.
  logic [2:0] choice1_d, choice2_d;
  logic       lock1_d, lock2_d;

  always_comb begin
    lock1_d   = lock1_q | lock1_p;
    lock2_d   = lock2_q | lock2_p;
    choice1_d = choice1_q;
    choice2_d = choice2_q;
    if (sel1_p && !lock1_d) choice1_d = next_choice(choice1_q);
    if (sel2_p && !lock2_d) choice2_d = next_choice(choice2_q);
  end

  // Round outcome: d = (c1 - c2) mod N; small positive d means player 1 beats
  // player 2. Operands are < N <= 7 so c1 + N - c2 fits in 4 bits.
  logic [3:0] diff;
  logic       p1_wins, p2_wins;
  logic [1:0] st1_res, st2_res;

  always_comb begin
    diff = {1'b0, choice1_q} + NCH4 - {1'b0, choice2_q};
    if (diff >= NCH4) diff = diff - NCH4;
    p1_wins = (diff != 4'd0) && (diff <= HALF4);
    p2_wins = (diff > HALF4);
    st1_res = p1_wins ? ST_WIN  : (p2_wins ? ST_LOSE : ST_LOCK);
    st2_res = p1_wins ? ST_LOSE : (p2_wins ? ST_WIN  : ST_LOCK);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_SELECT;
      rcnt_q       <= '0;
      choice1_q    <= '0;
      choice2_q    <= '0;
      lock1_q      <= 1'b0;
      lock2_q      <= 1'b0;
      value1_q     <= '0;
      value2_q     <= '0;
      score1_q     <= '0;
      score2_q     <= '0;
      round_done_q <= 1'b0;
    end else begin
      round_done_q <= 1'b0;
      case (state_q)
        S_SELECT: begin
          if (lock1_q && lock2_q) begin
            state_q      <= S_REVEAL;
            rcnt_q       <= '0;
            round_done_q <= 1'b1;
            value1_q     <= {st1_res, choice1_q};
            value2_q     <= {st2_res, choice2_q};
            if (p1_wins) score1_q <= sat_inc(score1_q);
            if (p2_wins) score2_q <= sat_inc(score2_q);
          end else begin
            choice1_q <= choice1_d;
            choice2_q <= choice2_d;
            lock1_q   <= lock1_d;
            lock2_q   <= lock2_d;
            value1_q  <= lock1_d ? {ST_LOCK, CODE_HIDDEN} : {ST_SEL, choice1_d};
            value2_q  <= lock2_d ? {ST_LOCK, CODE_HIDDEN} : {ST_SEL, choice2_d};
          end
        end
        S_REVEAL: begin
          // Button pulses are simply not looked at here, so they are dropped.
          if (rcnt_q == RCNT_LAST) begin
            state_q   <= S_SELECT;
            rcnt_q    <= '0;
            choice1_q <= '0;
            choice2_q <= '0;
            lock1_q   <= 1'b0;
            lock2_q   <= 1'b0;
            value1_q  <= {ST_SEL, 3'd0};
            value2_q  <= {ST_SEL, 3'd0};
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign value_player1 = value1_q;
  assign value_player2 = value2_q;
  assign score1        = score1_q;
  assign score2        = score2_q;
  assign round_done    = round_done_q;

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Bench for rps_round_ctrl: directed scenarios plus randomized button activity,
// every cycle compared against a behavioural model of the game rules.
module tb_rps_round_ctrl;

  localparam int DEB = 4;
  localparam int NCH = 3;
  localparam int REV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = 4'b0000;  // [0]=sel1 [1]=lock1 [2]=sel2 [3]=lock2
  logic [4:0] value_player1, value_player2;
  logic [3:0] score1, score2;
  logic       round_done;

  rps_round_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .NUM_CHOICES(NCH), .REVEAL_CYCLES(REV)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_sel1(btn[0]), .btn_lock1(btn[1]),
    .btn_sel2(btn[2]), .btn_lock2(btn[3]),
    .value_player1(value_player1), .value_player2(value_player2),
    .score1(score1), .score2(score2), .round_done(round_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A press is a run of DEB consecutive high raw samples; the spec latency puts
  // its effect on the game three edges after the run reaches DEB.
  int  edge_n = 0;
  int  run[4];
  int  fire_at[4];
  bit  ev[4];
  bit  chk_en = 1'b0;
  int  m_c1, m_c2, m_left, m_v1, m_v2, m_s1, m_s2, m_d;
  bit  m_l1, m_l2, m_done;

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      run[b] = 0;
      fire_at[b] = -1;
    end
    m_c1 = 0; m_c2 = 0; m_l1 = 0; m_l2 = 0; m_left = 0;
    m_v1 = 0; m_v2 = 0; m_s1 = 0; m_s2 = 0; m_done = 0;
    chk_en = 1'b1;
  endtask

  always @(posedge clk) begin
    edge_n++;
    if (!rst) begin
      model_reset();
    end else begin
      for (int b = 0; b < 4; b++) begin
        ev[b] = (fire_at[b] == edge_n);
        if (ev[b]) fire_at[b] = -1;
        run[b] = btn[b] ? run[b] + 1 : 0;
        if (run[b] == DEB) fire_at[b] = edge_n + 3;
      end
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_c1 = 0; m_c2 = 0; m_l1 = 0; m_l2 = 0; m_v1 = 0; m_v2 = 0;
        end
      end else if (m_l1 && m_l2) begin
        m_d = (((m_c1 - m_c2) % NCH) + NCH) % NCH;
        if (m_d == 0) begin
          m_v1 = 8 + m_c1; m_v2 = 8 + m_c2;
        end else if (m_d <= (NCH - 1) / 2) begin
          m_v1 = 16 + m_c1; m_v2 = 24 + m_c2;
          if (m_s1 < 9) m_s1++;
        end else begin
          m_v1 = 24 + m_c1; m_v2 = 16 + m_c2;
          if (m_s2 < 9) m_s2++;
        end
        m_left = REV;
        m_done = 1;
      end else begin
        if (ev[1]) m_l1 = 1;
        else if (ev[0] && !m_l1) m_c1 = (m_c1 + 1) % NCH;
        if (ev[3]) m_l2 = 1;
        else if (ev[2] && !m_l2) m_c2 = (m_c2 + 1) % NCH;
        m_v1 = m_l1 ? 15 : m_c1;
        m_v2 = m_l2 ? 15 : m_c2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("value1", value_player1, m_v1);
      chk("value2", value_player2, m_v2);
      chk("score1", score1, m_s1);
      chk("score2", score2, m_s2);
      chk("round_done", round_done, m_done);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] mask, input int n);
    btn = mask;
    repeat (n) @(negedge clk);
    btn = 4'b0000;
  endtask

  task automatic press(input logic [3:0] mask);
    hold(mask, 6);
    idle(3);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (round_done !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk(tag, round_done, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b0;
    idle(3);
    chk("rst_v1", value_player1, 0);
    chk("rst_v2", value_player2, 0);
    chk("rst_done", round_done, 0);
    rst = 1'b1;
    idle(2);

    // Glitch shorter than the debounce window.
    hold(4'b0001, 3);
    idle(8);
    chk("glitch_v1", value_player1, 0);

    // Six-cycle press: still 0 after edge k+5, 00001 after edge k+6.
    hold(4'b0001, 6);
    chk("deb_early", value_player1, 0);
    @(negedge clk);
    chk("deb_lat", value_player1, 1);
    idle(6);
    chk("deb_single", value_player1, 1);

    // Wrap, then select 1 and lock; further sel ignored.
    press(4'b0001);
    press(4'b0001);
    chk("wrap_v1", value_player1, 0);
    press(4'b0001);
    press(4'b0010);
    chk("lock_v1", value_player1, 15);
    press(4'b0001);
    chk("lock_hold_v1", value_player1, 15);

    // Player 1 (choice 1) beats player 2 (choice 0).
    hold(4'b1000, 6);
    wait_done("p1win_done");
    chk("p1win_v1", value_player1, 17);
    chk("p1win_v2", value_player2, 24);
    chk("p1win_s1", score1, 1);
    idle(REV);
    chk("p1win_end_v1", value_player1, 0);
    chk("p1win_end_v2", value_player2, 0);

    // Draw on choice 2 with a simultaneous lock.
    press(4'b0101);
    press(4'b0101);
    hold(4'b1010, 6);
    wait_done("draw_done");
    chk("draw_v1", value_player1, 10);
    chk("draw_v2", value_player2, 10);
    chk("draw_s1", score1, 1);
    chk("draw_s2", score2, 0);
    idle(REV + 1);

    // Ten player-2 wins with sel presses thrown in during REVEAL.
    for (int r = 0; r < 10; r++) begin
      press(4'b0100);
      hold(4'b1010, 6);
      wait_done("p2win_done");
      hold(4'b0101, 5);
      idle(6);
      chk("p2win_next_v1", value_player1, 0);
      chk("p2win_next_v2", value_player2, 0);
    end
    chk("sat_s2", score2, 9);
    chk("sat_s1", score1, 1);

    // Raise score1 to 3, lock p1, then reset for one cycle.
    for (int r = 0; r < 2; r++) begin
      press(4'b0001);
      hold(4'b1010, 6);
      wait_done("p1win2_done");
      idle(REV + 1);
    end
    chk("pre_rst_s1", score1, 3);
    press(4'b0010);
    chk("pre_rst_v1", value_player1, 15);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_v1", value_player1, 0);
    chk("mid_rst_v2", value_player2, 0);
    chk("mid_rst_s1", score1, 0);
    chk("mid_rst_s2", score2, 0);
    chk("mid_rst_done", round_done, 0);
    press(4'b0100);
    hold(4'b1010, 6);
    wait_done("post_rst_done");
    chk("post_rst_s2", score2, 1);
    chk("post_rst_s1", score1, 0);
    idle(REV + 1);

    // Random button activity, including sub-window glitches and rare resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
      hold(4'($urandom), int'($urandom_range(1, 9)));
      idle(int'($urandom_range(0, 3)));
    end
    idle(REV + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rps_round_ctrl.md
# rps_round_ctrl

Two-player round controller that turns raw push-button inputs into the per-player 5-bit values consumed by the `display` / `seven_segment` output path. It debounces four buttons, lets each player cycle and lock a hidden choice, and resolves the round with a generalized rock-paper-scissors rule once both players have locked. It then shows the result for a fixed time and keeps saturating per-player scores.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive high samples required before a press is accepted.
- `NUM_CHOICES`, default 3: number of selectable choices. Must be odd, 3..7.
- `REVEAL_CYCLES`, default 16: number of cycles the result is shown before a new round starts.
- `clk` in, 1: system clock. All logic is on the rising edge.
- `rst` in, 1: reset, synchronous, active-low.
- `btn_sel1`, `btn_lock1` in, 1 each: player 1 raw buttons, asynchronous, active-high.
- `btn_sel2`, `btn_lock2` in, 1 each: player 2 raw buttons, same conventions.
- `value_player1` out, 5: `{status[1:0], code[2:0]}` for player 1. Registered.
- `value_player2` out, 5: same encoding for player 2.
- `score1`, `score2` out, 4 each: round wins per player, saturating at 9.
- `round_done` out, 1: one-cycle pulse on entry to REVEAL.

## Operation
- **Status field:** 00 = selecting, 01 = locked or draw, 10 = win, 11 = lose.
- **Code field:** current choice `0..NUM_CHOICES-1`. Code 7 means hidden (displayed blank).
- **Button processing:** each button passes through a 2-FF synchronizer and then a stable-high counter.
  - A one-cycle press pulse fires when the counter reaches `DEBOUNCE_CYCLES`.
  - No further pulse fires until the synchronized input has been low for at least one cycle.
- **States:** SELECT, REVEAL.
- **In SELECT:**
  - A sel pulse on an unlocked player increments that player's choice, wrapping `NUM_CHOICES-1` to 0.
  - A lock pulse sets that player's lock flag.
  - Once a player is locked, their output is `{01, 3'b111}` and further sel pulses are ignored.
  - An unlocked player's output is `{00, choice}`.
- **SELECT -> REVEAL:** happens in the cycle after both lock flags are set. This includes both locks arriving in the same cycle.
- **On entry to REVEAL:**
  - Compute `d = (c1 - c2) mod NUM_CHOICES`.
  - d = 0: both players get status 01 (draw).
  - d in `1..(NUM_CHOICES-1)/2`: player 1 gets 10, player 2 gets 11.
  - Otherwise: player 1 gets 11, player 2 gets 10.
  - Both codes show the real choices.
  - The winner's score increments, saturating at 9.
  - `round_done` pulses.
- **In REVEAL:** all button pulses are ignored (discarded, not queued).
- **REVEAL -> SELECT:** after exactly `REVEAL_CYCLES` cycles. Choices reset to 0, lock flags clear, outputs become `{00, 000}`.
- **Same-cycle sel and lock, same player:** lock wins and the choice does not change.
- **Reset while rst = 0:** state SELECT, choices 0, locks 0, debounce counters and synchronizers 0, scores 0, `value_player*` = 5'b00000, `round_done` = 0. Applies mid-round too; scores are not retained.

## Timing
- **Press-pulse latency:** a raw input sampled high at edge k and held high produces its press pulse at edge `k + 2 + DEBOUNCE_CYCLES - 1`.
- **Output update:** `value_player*` updates one edge after the press pulse.
- **Glitches:** a high glitch shorter than `DEBOUNCE_CYCLES` samples produces no pulse.
- **Round resolution:** at the edge where the second lock flag sets, the state is still SELECT. At the next edge, REVEAL is entered, outputs and scores update, and `round_done` is 1 for that cycle only.
- **Reveal window:** REVEAL lasts `REVEAL_CYCLES` cycles. SELECT outputs appear at the following edge.
- **Score saturation:** a score at 9 stays at 9 on a further win.

## Structure
- **Shared package** (`rps_pkg`):
  - Status constants `ST_SEL`, `ST_LOCK`, `ST_WIN`, `ST_LOSE`.
  - `CODE_HIDDEN = 3'd7`.
  - `SCORE_MAX = 4'd9`.
  - The state encoding.
- **Sub-module** `btn_debounce`: synchronizer, counter and press-pulse logic, parameterized by `DEBOUNCE_CYCLES`. Instantiated four times.
- **Top:** FSM, choice registers, lock flags, win compare, scores and reveal counter.

## Test plan
Test parameters: `DEBOUNCE_CYCLES` = 4, `NUM_CHOICES` = 3, `REVEAL_CYCLES` = 8.

- **Debounce:** a 3-cycle high pulse on `btn_sel1` leaves `value_player1` = 00000. A 6-cycle high pulse gives 00001 exactly 6 edges after the first high sample, with a single increment.
- **Wrap and hide:** three sel1 presses give code 0 (wrapped). Then sel1 once, then lock1, gives `value_player1` = 01111. A further sel1 press leaves it unchanged.
- **Player 1 wins:** p1 locks choice 1, p2 locks choice 0. REVEAL gives `value_player1` = 10001, `value_player2` = 11000, `score1` = 1, a one-cycle `round_done`, then 00000/00000 after 8 cycles.
- **Draw, simultaneous lock:** both players choose 2 and lock in the same cycle. Both outputs show 01010 and scores are unchanged.
- **Saturation and ignored input:** ten rounds won by p2 leave `score2` = 9. Sel presses during REVEAL have no effect on the next round, which starts at choice 0.
- **Reset mid-operation:** rst low for 1 cycle while p1 is locked and `score1` = 3. Next cycle all outputs are 0, and the next round behaves as after power-up.
